// File: rtl/modulo_transmisor_hamming.sv
// Hamming(7,4)+overall-parity encoder with a UART-style serialiser (start, 8 data LSB first, stop).
// Optional macro INYECCION_ERROR_EN adds port mascara_error, XORed into the word at accept.
module modulo_transmisor_hamming #(
  parameter int unsigned CICLOS_POR_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] datos_entrada,
  input  logic       dato_valido,
`ifdef INYECCION_ERROR_EN
  input  logic [7:0] mascara_error,
`endif
  output logic       listo,
  output logic [7:0] palabra_codificada,
  output logic       palabra_valida,
  output logic       tx,
  output logic       ocupado
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_POR_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(7);

  typedef enum logic [1:0] {REPOSO, INICIO, DATOS, PARADA} estado_t;

  estado_t          estado, estado_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       palabra_n;
  logic [7:0]       mascara;
  logic             tx_n, listo_n, ocupado_n, valida_n;
  logic             aceptar, fin_bit;

`ifdef INYECCION_ERROR_EN
  assign mascara = mascara_error;
`else
  assign mascara = 8'h00;
`endif

  // Word layout {p0,d4,d3,d2,p3,d1,p2,p1}; p0 makes the whole byte even parity.
  function automatic logic [7:0] codificar(input logic [3:0] d);
    logic [6:0] w;
    w[0] = d[0] ^ d[1] ^ d[3];
    w[1] = d[0] ^ d[2] ^ d[3];
    w[2] = d[0];
    w[3] = d[1] ^ d[2] ^ d[3];
    w[4] = d[1];
    w[5] = d[2];
    w[6] = d[3];
    return {^w, w};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      estado             <= REPOSO;
      cnt                <= '0;
      idx                <= '0;
      palabra_codificada <= 8'h00;
      tx                 <= 1'b1;
      listo              <= 1'b0;
      ocupado            <= 1'b0;
      palabra_valida     <= 1'b0;
    end else begin
      estado             <= estado_n;
      cnt                <= cnt_n;
      idx                <= idx_n;
      palabra_codificada <= palabra_n;
      tx                 <= tx_n;
      listo              <= listo_n;
      ocupado            <= ocupado_n;
      palabra_valida     <= valida_n;
    end
  end

  // Next state and counters; outputs are derived from the next state so they are registered.
  always_comb begin
    estado_n  = estado;
    cnt_n     = cnt;
    idx_n     = idx;
    palabra_n = palabra_codificada;
    aceptar   = 1'b0;
    fin_bit   = (cnt == CNT_MAX);

    case (estado)
      REPOSO: begin
        if (dato_valido && listo) begin
          aceptar   = 1'b1;
          estado_n  = INICIO;
          cnt_n     = '0;
          idx_n     = '0;
          palabra_n = codificar(datos_entrada) ^ mascara;
        end
      end
      INICIO: begin
        if (fin_bit) begin
          cnt_n    = '0;
          estado_n = DATOS;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATOS: begin
        if (fin_bit) begin
          cnt_n = '0;
          if (idx == IDX_MAX) begin
            idx_n    = '0;
            estado_n = PARADA;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARADA: begin
        if (fin_bit) begin
          cnt_n    = '0;
          estado_n = REPOSO;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: estado_n = REPOSO;
    endcase

    case (estado_n)
      INICIO:  tx_n = 1'b0;
      DATOS:   tx_n = palabra_n[idx_n];
      default: tx_n = 1'b1;
    endcase
    listo_n   = (estado_n == REPOSO);
    ocupado_n = (estado_n != REPOSO);
    valida_n  = aceptar;
  end

endmodule
